ring_pulse_generator: RTL and testbench
=======================================

Name: ring_pulse_generator

Overview:
- Programmable pulse-train source.
- Emits exactly N single-cycle pulses, evenly spread, in every gate window of WINDOW clock cycles.
- It is the stimulus end of the team's windowed edge-counting measurement path: a counter gated over the same WINDOW-cycle window must read back N.
- The target value is loaded through a valid/ready handshake and takes effect only at a window boundary, so no window ever mixes two values.

Parameters:
WINDOW, 100, gate window length in clk cycles (even, >= 4)
MAXP, WINDOW/2, maximum pulses per window (derived; guarantees at least one low cycle between pulses)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
enable  input  1  1 = run pulse generation; 0 = idle
set_valid  input  1  new pulse count offered
set_value  input  16  requested pulses per window
set_ready  output  1  pending slot empty; offer is accepted when set_valid && set_ready
pulse_out  output  1  generated pulse train, one cycle high per pulse
window_start  output  1  high for the first cycle of each window (wcnt == 0) while running
active_value  output  16  pulse count applied to the current window, after clamping
clamped  output  1  active_value was limited to MAXP
pulses_emitted  output  16  pulses counted in the last completed window

Behaviour:
- Reset, while rst_n == 0 at a rising edge:
  - state = IDLE.
  - wcnt, acc, pulse counter, pulses_emitted, active_value = 0.
  - pulse_out, window_start, clamped = 0.
  - Pending slot empty, so set_ready = 1.
  - Reset during RUN aborts the window immediately; no partial count is latched.
- Handshake:
  - set_ready = !pending_valid.
  - On an accept edge: pending <= set_value, pending_valid <= 1.
  - Accepts are allowed in IDLE and RUN.
  - An accept and a boundary on the same edge: the boundary uses the state before that edge, and the new value waits for the next boundary.
- Boundary edge. This is either the IDLE->RUN edge (enable = 1 in IDLE) or a RUN edge with wcnt == WINDOW-1. On that edge:
  - If pending_valid: active_value <= min(pending, MAXP); clamped <= (pending > MAXP); pending_valid <= 0. Otherwise both hold.
  - acc <= new active_value; wcnt <= 0; pulse_out <= 0.
  - pulses_emitted <= pulse counter + pulse_out. Only a RUN-to-RUN boundary latches this; the IDLE->RUN edge leaves it unchanged.
  - Pulse counter <= 0.
- Non-boundary RUN edge:
  - wcnt <= wcnt + 1.
  - sum = acc + active_value, computed in 17 bits. If sum >= WINDOW: acc <= sum - WINDOW and pulse_out <= 1. Otherwise acc <= sum and pulse_out <= 0.
  - Pulse counter increments on each edge where pulse_out is currently 1.
- Resulting timing:
  - Exactly active_value pulses per window.
  - Pulses only occur at wcnt in 1..WINDOW-1.
  - For N >= 1 the last pulse falls at wcnt == WINDOW-1.
  - active_value <= WINDOW/2, so two consecutive high cycles are impossible.
- window_start = (state == RUN) && (wcnt == 0), registered alongside wcnt.
- RUN -> IDLE: the first edge with enable == 0.
  - pulse_out, window_start, wcnt, acc, pulse counter <= 0.
  - pulses_emitted, active_value, clamped, pending hold.
  - The partial window is discarded.
- N = 0: no pulses; at each boundary pulses_emitted becomes 0.
- set_value > 65535 is impossible. Any value > MAXP clamps.

Test Plan (WINDOW = 100):
- Reset, then enable = 1 with no value loaded -> pulse_out stays 0; window_start every 100 cycles; pulses_emitted = 0.
- Accept 37, enable = 1 -> 37 applies from the first window (IDLE->RUN boundary); every window has 37 pulses, none adjacent; pulses_emitted = 37 after the first window; last pulse at wcnt 99.
- Running at 10; accept 25 mid-window (wcnt = 40) -> current window completes with 10 pulses; next window 25; set_ready low from accept until that boundary; second accept while pending is refused.
- Accept 80 -> active_value = 50, clamped = 1, 50 pulses per window with a strict alternating pattern.
- Accept on the same edge as a boundary (wcnt = 99, pending empty) -> the value waits one full window before applying.
- Drop enable at wcnt = 60, then reset mid-window -> pulse_out = 0 the next cycle; pulses_emitted keeps the prior value until reset clears it to 0; set_ready = 1 after reset.

Source files
------------

// File: rtl/ring_pulse_generator_if.sv
// ---------------------------------------------------------------------------
// ring_pulse_generator_if
// Purpose : groups the control, handshake and status signals of the
//           ring_pulse_generator into one bundle.
// Signals :
//   enable         1 = run pulse generation, 0 = idle
//   set_valid      new pulse count offered
//   set_value[16]  requested pulses per window
//   set_ready      pending slot empty (offer accepted on set_valid && set_ready)
//   pulse_out      generated pulse train, one cycle high per pulse
//   window_start   high on the first cycle of each running window
//   active_value   pulse count applied to the current window (clamped)
//   clamped        active_value was limited to the per-window maximum
//   pulses_emitted pulses counted in the last completed window
// Modports: master drives the controls (test/host side), slave is the generator.
// ---------------------------------------------------------------------------
interface ring_pulse_generator_if;
   logic        enable;
   logic        set_valid;
   logic [15:0] set_value;
   logic        set_ready;
   logic        pulse_out;
   logic        window_start;
   logic [15:0] active_value;
   logic        clamped;
   logic [15:0] pulses_emitted;

   modport master (
      output enable, set_valid, set_value,
      input  set_ready, pulse_out, window_start, active_value, clamped, pulses_emitted
   );

   modport slave (
      input  enable, set_valid, set_value,
      output set_ready, pulse_out, window_start, active_value, clamped, pulses_emitted
   );
endinterface

// File: rtl/ring_pulse_generator.sv
// ---------------------------------------------------------------------------
// ring_pulse_generator
// Purpose : emits exactly active_value single-cycle pulses, evenly spread,
//           in every window of WINDOW clock cycles. A new count is loaded via
//           a valid/ready handshake and only takes effect at a window
//           boundary, so no window ever mixes two counts.
// Ports   :
//   clk    system clock, all logic on the rising edge
//   rst_n  synchronous active-low reset
//   bus    ring_pulse_generator_if.slave (controls, handshake, status)
// Spreading works like a phase accumulator: every cycle acc grows by N and
// a pulse is emitted whenever it crosses WINDOW. Seeding acc with N at the
// boundary makes the N-th crossing land exactly on the last cycle.
// ---------------------------------------------------------------------------
module ring_pulse_generator #(
   parameter int WINDOW = 100
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ring_pulse_generator_if.slave  bus
);

   localparam int MAXP   = WINDOW / 2;
   localparam int WCNT_W = $clog2(WINDOW);
   localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WINDOW - 1);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   // Limits a requested count so at least one low cycle separates pulses.
   function automatic logic [15:0] f_clamp(input logic [15:0] v);
      return (v > 16'(MAXP)) ? 16'(MAXP) : v;
   endfunction

   state_t              r_state;
   state_t              w_state_next;
   logic [WCNT_W-1:0]   r_wcnt;
   logic [15:0]         r_acc;
   logic [15:0]         r_pcnt;
   logic [15:0]         r_emitted;
   logic [15:0]         r_active;
   logic                r_clamped;
   logic                r_pulse;
   logic                r_wstart;
   logic [15:0]         r_pending;
   logic                r_pend_valid;

   logic                w_boundary;
   logic                w_wrap;
   logic                w_step;
   logic                w_stop;
   logic                w_accept;
   logic [16:0]         w_sum;
   logic                w_over;
   logic [15:0]         w_new_active;

   assign w_accept     = bus.set_valid && !r_pend_valid;
   assign w_sum        = 17'(r_acc) + 17'(r_active);
   assign w_over       = (w_sum >= 17'(WINDOW));
   assign w_new_active = r_pend_valid ? f_clamp(r_pending) : r_active;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Next state and per-edge event decode. Dropping enable wins over a
   // boundary, so the last cycle of a window can still abort it.
   always_comb begin
      w_state_next = r_state;
      w_boundary   = 1'b0;
      w_wrap       = 1'b0;
      w_step       = 1'b0;
      w_stop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.enable) begin
               w_state_next = ST_RUN;
               w_boundary   = 1'b1;
            end
         end
         ST_RUN: begin
            if (!bus.enable) begin
               w_state_next = ST_IDLE;
               w_stop       = 1'b1;
            end else if (r_wcnt == WLAST) begin
               w_boundary = 1'b1;
               w_wrap     = 1'b1;
            end else begin
               w_step = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Datapath: window counter, accumulator, pulse counting and handshake
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wcnt       <= '0;
         r_acc        <= '0;
         r_pcnt       <= '0;
         r_emitted    <= '0;
         r_active     <= '0;
         r_clamped    <= 1'b0;
         r_pulse      <= 1'b0;
         r_wstart     <= 1'b0;
         r_pending    <= '0;
         r_pend_valid <= 1'b0;
      end else begin
         // An accept only happens with the slot empty, so it never collides
         // with the boundary clearing a full slot.
         if (w_accept) begin
            r_pending    <= bus.set_value;
            r_pend_valid <= 1'b1;
         end
         if (w_boundary) begin
            if (r_pend_valid) begin
               r_active     <= f_clamp(r_pending);
               r_clamped    <= (r_pending > 16'(MAXP));
               r_pend_valid <= 1'b0;
            end
            r_acc    <= w_new_active;
            r_wcnt   <= '0;
            r_pulse  <= 1'b0;
            r_wstart <= 1'b1;
            r_pcnt   <= '0;
            // The pulse on the final cycle is still in r_pulse here.
            if (w_wrap) r_emitted <= r_pcnt + 16'(r_pulse);
         end else if (w_step) begin
            r_wcnt   <= r_wcnt + WCNT_W'(1);
            r_wstart <= 1'b0;
            r_acc    <= w_over ? 16'(w_sum - 17'(WINDOW)) : 16'(w_sum);
            r_pulse  <= w_over;
            if (r_pulse) r_pcnt <= r_pcnt + 16'd1;
         end else if (w_stop) begin
            r_wcnt   <= '0;
            r_acc    <= '0;
            r_pcnt   <= '0;
            r_pulse  <= 1'b0;
            r_wstart <= 1'b0;
         end
      end
   end

   assign bus.set_ready      = !r_pend_valid;
   assign bus.pulse_out      = r_pulse;
   assign bus.window_start   = r_wstart;
   assign bus.active_value   = r_active;
   assign bus.clamped        = r_clamped;
   assign bus.pulses_emitted = r_emitted;

endmodule

// File: tb/tb_ring_pulse_generator.sv
// ---------------------------------------------------------------------------
// tb_ring_pulse_generator
// Directed bench for ring_pulse_generator with WINDOW = 100. The bench keeps
// its own window position (g_wcnt) and gathers per-window pulse statistics
// from pulse_out; expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_ring_pulse_generator;

   logic clk = 1'b0;
   logic rst_n;

   ring_pulse_generator_if bus ();

   ring_pulse_generator #(.WINDOW(100)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int g_wcnt;
   int g_pulses;
   int g_first;
   int g_last;
   int g_adj;
   int g_ws_bad;
   bit g_prev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      g_pulses = 0;
      g_first  = -1;
      g_last   = -1;
      g_adj    = 0;
      g_ws_bad = 0;
      g_prev   = 1'b0;
   endtask

   // One clock while running: advances the bench's window position and
   // records what pulse_out / window_start did at that position.
   task automatic tick_run();
      tick();
      g_wcnt = (g_wcnt == 99) ? 0 : g_wcnt + 1;
      if (bus.pulse_out === 1'b1) begin
         g_pulses++;
         if (g_prev) g_adj++;
         if (g_first < 0) g_first = g_wcnt;
         g_last = g_wcnt;
      end
      g_prev = (bus.pulse_out === 1'b1);
      if (bus.window_start !== (g_wcnt == 0)) g_ws_bad++;
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) tick_run();
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.enable    = 1'b0;
      bus.set_valid = 1'b0;
      bus.set_value = 16'd0;
      g_wcnt        = 0;
      clear_stats();

      // Reset state
      repeat (3) tick();
      check("rst_pulse_out", bus.pulse_out, 0);
      check("rst_window_start", bus.window_start, 0);
      check("rst_active_value", bus.active_value, 0);
      check("rst_clamped", bus.clamped, 0);
      check("rst_pulses_emitted", bus.pulses_emitted, 0);
      check("rst_set_ready", bus.set_ready, 1);

      // Run with nothing loaded: N = 0
      rst_n      = 1'b1;
      bus.enable = 1'b1;
      tick();
      g_wcnt = 0;
      check("n0_first_window_start", bus.window_start, 1);
      clear_stats();
      run_n(100);
      check("n0_pulses", g_pulses, 0);
      check("n0_window_start_pattern", g_ws_bad, 0);
      check("n0_pulses_emitted", bus.pulses_emitted, 0);

      // Back to idle, load 37 there, then start
      bus.enable = 1'b0;
      tick();
      check("idle_pulse_out", bus.pulse_out, 0);
      check("idle_window_start", bus.window_start, 0);
      bus.set_valid = 1'b1;
      bus.set_value = 16'd37;
      tick();
      bus.set_valid = 1'b0;
      check("n37_pending_ready", bus.set_ready, 0);
      bus.enable = 1'b1;
      tick();
      g_wcnt = 0;
      check("n37_active_value", bus.active_value, 37);
      check("n37_ready_after_apply", bus.set_ready, 1);
      check("n37_clamped", bus.clamped, 0);
      check("n37_window_start", bus.window_start, 1);
      clear_stats();
      run_n(100);
      check("n37_w1_pulses", g_pulses, 37);
      check("n37_w1_first", g_first, 2);
      check("n37_w1_last", g_last, 99);
      check("n37_w1_adjacent", g_adj, 0);
      check("n37_w1_emitted", bus.pulses_emitted, 37);
      check("n37_w1_ws_pattern", g_ws_bad, 0);
      clear_stats();
      run_n(100);
      check("n37_w2_pulses", g_pulses, 37);
      check("n37_w2_emitted", bus.pulses_emitted, 37);

      // Switch to 10 (offer at wcnt 0, applies next boundary)
      clear_stats();
      bus.set_valid = 1'b1;
      bus.set_value = 16'd10;
      tick_run();
      bus.set_valid = 1'b0;
      check("n10_pending_ready", bus.set_ready, 0);
      run_n(99);
      check("n10_prev_window_pulses", g_pulses, 37);
      check("n10_active_value", bus.active_value, 10);
      check("n10_prev_emitted", bus.pulses_emitted, 37);
      check("n10_ready_after_apply", bus.set_ready, 1);

      // Running at 10: offer 25 at wcnt 40, then a refused second offer
      clear_stats();
      run_n(40);
      bus.set_valid = 1'b1;
      bus.set_value = 16'd25;
      tick_run();
      check("n25_ready_after_accept", bus.set_ready, 0);
      bus.set_value = 16'd99;
      tick_run();
      check("n25_second_offer_refused_ready", bus.set_ready, 0);
      bus.set_valid = 1'b0;
      run_n(58);
      check("n10_pulses", g_pulses, 10);
      check("n10_first", g_first, 9);
      check("n10_last", g_last, 99);
      check("n10_emitted", bus.pulses_emitted, 10);
      check("n25_active_value", bus.active_value, 25);
      check("n25_clamped", bus.clamped, 0);
      clear_stats();
      run_n(100);
      check("n25_pulses", g_pulses, 25);
      check("n25_last", g_last, 99);
      check("n25_adjacent", g_adj, 0);
      check("n25_emitted", bus.pulses_emitted, 25);

      // Offer 80: clamps to 50, strict alternation
      clear_stats();
      bus.set_valid = 1'b1;
      bus.set_value = 16'd80;
      tick_run();
      bus.set_valid = 1'b0;
      run_n(99);
      check("clamp_prev_pulses", g_pulses, 25);
      check("clamp_active_value", bus.active_value, 50);
      check("clamp_flag", bus.clamped, 1);
      clear_stats();
      run_n(100);
      check("clamp_pulses", g_pulses, 50);
      check("clamp_first", g_first, 1);
      check("clamp_last", g_last, 99);
      check("clamp_adjacent", g_adj, 0);
      check("clamp_emitted", bus.pulses_emitted, 50);

      // Offer 20 on the boundary edge itself: waits one full window
      clear_stats();
      run_n(99);
      bus.set_valid = 1'b1;
      bus.set_value = 16'd20;
      tick_run();
      bus.set_valid = 1'b0;
      check("edge_offer_active_held", bus.active_value, 50);
      check("edge_offer_clamped_held", bus.clamped, 1);
      check("edge_offer_ready", bus.set_ready, 0);
      clear_stats();
      run_n(100);
      check("edge_offer_wait_pulses", g_pulses, 50);
      check("edge_offer_active_applied", bus.active_value, 20);
      check("edge_offer_clamped_cleared", bus.clamped, 0);
      check("edge_offer_ready_after", bus.set_ready, 1);
      clear_stats();
      run_n(100);
      check("n20_pulses", g_pulses, 20);
      check("n20_first", g_first, 4);
      check("n20_emitted", bus.pulses_emitted, 20);
      check("n20_ws_pattern", g_ws_bad, 0);

      // Drop enable at wcnt 60: partial window discarded
      run_n(60);
      bus.enable = 1'b0;
      tick();
      check("stop_pulse_out", bus.pulse_out, 0);
      check("stop_window_start", bus.window_start, 0);
      check("stop_emitted_held", bus.pulses_emitted, 20);
      check("stop_active_held", bus.active_value, 20);
      repeat (5) tick();
      check("idle_pulse_out_quiet", bus.pulse_out, 0);

      // Restart, leave a value pending, then reset mid-window
      bus.enable = 1'b1;
      tick();
      g_wcnt = 0;
      clear_stats();
      run_n(30);
      bus.set_valid = 1'b1;
      bus.set_value = 16'd5;
      tick_run();
      bus.set_valid = 1'b0;
      check("pre_rst_ready", bus.set_ready, 0);
      check("pre_rst_emitted", bus.pulses_emitted, 20);
      rst_n = 1'b0;
      tick();
      check("mid_rst_pulse_out", bus.pulse_out, 0);
      check("mid_rst_window_start", bus.window_start, 0);
      check("mid_rst_emitted", bus.pulses_emitted, 0);
      check("mid_rst_active", bus.active_value, 0);
      check("mid_rst_clamped", bus.clamped, 0);
      check("mid_rst_ready", bus.set_ready, 1);
      rst_n      = 1'b1;
      bus.enable = 1'b0;
      repeat (3) tick();
      check("post_rst_pulse_out", bus.pulse_out, 0);
      check("post_rst_active", bus.active_value, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
